cpu_run_ctrl: RTL

//   Run/step/halt sequencer between the FPGA board inputs and the pipelined RISC-V core.

---
 rtl/cpu_run_ctrl_if.sv | 12 +
 rtl/cpu_run_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: board inputs, core halt request and core control/status outputs
interface cpu_run_ctrl_if #(parameter int CYC_W = 32);
   logic             sw_run;
   logic             btn_step;
   logic             halt_req;
   logic             cpu_rst;
   logic             cpu_ce;
   logic [CYC_W-1:0] cycle_cnt;
   logic [1:0]       led_state;
   modport master (input sw_run, btn_step, halt_req, output cpu_rst, cpu_ce, cycle_cnt, led_state);
   modport slave  (output sw_run, btn_step, halt_req, input cpu_rst, cpu_ce, cycle_cnt, led_state);
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: reset stretch, run/step/halt sequencing and core clock-enable generation
module cpu_run_ctrl #(
   parameter int RST_HOLD_CYCLES = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CYC_W           = 32
) (
   input logic            clk,
   input logic            rst,
   cpu_run_ctrl_if.master bus
);
   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {POR = 2'b00, HALT = 2'b01, RUN = 2'b10, STEP = 2'b11} state_t;
   state_t           state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [1:0]       sw_sync_q, sw_sync_d, btn_sync_q, btn_sync_d;
   logic [DW-1:0]    db_cnt_q, db_cnt_d;
   logic             btn_db_q, btn_db_d, btn_db_prev_q, btn_db_prev_d;
   logic             halt_lat_q, halt_lat_d;
   logic [CYC_W-1:0] cycle_q, cycle_d;
   logic             sw_s, btn_s, step_pulse, ce;
   assign sw_s       = sw_sync_q[1];
   assign btn_s      = btn_sync_q[1];
   assign step_pulse = btn_db_q & ~btn_db_prev_q;
   assign ce         = (state_q == RUN) || (state_q == STEP);
   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= POR;
      else     state_q <= state_d;
   end
   // Next-state logic: RUN wins over STEP in HALT; STEP lasts exactly one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         POR:     state_d = (hold_q == HW'(RST_HOLD_CYCLES - 1)) ? (sw_s ? RUN : HALT) : POR;
         HALT:    state_d = (sw_s && !halt_lat_q) ? RUN : (step_pulse ? STEP : HALT);
         RUN:     state_d = (bus.halt_req || !sw_s) ? HALT : RUN;
         default: state_d = HALT;
      endcase
   end
   // Moore outputs decoded straight from the state register
   always_comb begin
      bus.cpu_rst   = state_q == POR;
      bus.cpu_ce    = ce;
      bus.led_state = state_q;
      bus.cycle_cnt = cycle_q;
   end
   // Synchronizers, debounce, reset-hold count, sticky halt latch and cycle counter
   always_comb begin
      sw_sync_d     = {sw_sync_q[0], bus.sw_run};
      btn_sync_d    = {btn_sync_q[0], bus.btn_step};
      btn_db_d      = btn_db_q;
      db_cnt_d      = '0;
      if (btn_s != btn_db_q) begin
         if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) btn_db_d = btn_s;
         else db_cnt_d = db_cnt_q + 1'b1;
      end
      btn_db_prev_d = btn_db_q;
      hold_d        = (state_q == POR) ? hold_q + 1'b1 : '0;
      halt_lat_d    = (bus.halt_req && ce) ? 1'b1 : (!sw_s ? 1'b0 : halt_lat_q);
      cycle_d       = cycle_q + CYC_W'(ce);
   end
   // Datapath registers, all cleared by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_sync_q     <= '0;
         btn_sync_q    <= '0;
         btn_db_q      <= 1'b0;
         btn_db_prev_q <= 1'b0;
         db_cnt_q      <= '0;
         hold_q        <= '0;
         halt_lat_q    <= 1'b0;
         cycle_q       <= '0;
      end else begin
         sw_sync_q     <= sw_sync_d;
         btn_sync_q    <= btn_sync_d;
         btn_db_q      <= btn_db_d;
         btn_db_prev_q <= btn_db_prev_d;
         db_cnt_q      <= db_cnt_d;
         hold_q        <= hold_d;
         halt_lat_q    <= halt_lat_d;
         cycle_q       <= cycle_d;
      end
   end
endmodule
